// File: rtl/dice_race_turn_fsm.sv
// Dice race turn sequencer: accepts colour rolls, animates stepped movement and detects the winner.
// Optional DICE_BONUS_ROLL_EN: a non-winning BLUE roll grants the same player another turn.
module dice_race_turn_fsm #(
  parameter int NUM_PLAYERS = 2,
  parameter int TRACK_LEN   = 30,
  parameter int RED_STEPS   = 1,
  parameter int GREEN_STEPS = 2,
  parameter int BLUE_STEPS  = 3,
  parameter int STEP_TICKS  = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  stable_color,
  input  logic        result_ready,
  input  logic        turn_end,
  input  logic        current_state_white,
  output logic [2:0]  state,
  output logic [1:0]  cur_player,
  output logic [23:0] player_pos,
  output logic [1:0]  last_roll,
  output logic        step_pulse,
  output logic        winner_valid,
  output logic [1:0]  winner
);

  localparam int TW = $clog2(STEP_TICKS);
  localparam logic [TW-1:0] TICK_LAST   = TW'(STEP_TICKS - 1);
  localparam logic [5:0]    TRACK_END   = 6'(TRACK_LEN);
  localparam logic [1:0]    LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [1:0]    COLOR_BLUE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ROLL  = 3'd1,
    MOVE       = 3'd2,
    WAIT_CLEAR = 3'd3,
    GAME_OVER  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [5:0]      pos_q [4];
  logic [5:0]      pos_d [4];
  logic [1:0]      roll_q, roll_d;
  logic [2:0]      steps_q, steps_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            pulse_q, pulse_d;
  logic            win_valid_q, win_valid_d;
  logic [1:0]      winner_q, winner_d;
  logic [2:0]      roll_steps;
  logic [5:0]      pos_inc;
  logic            keep_player;

  always_comb begin
    case (stable_color)
      2'b01:   roll_steps = 3'(RED_STEPS);
      2'b10:   roll_steps = 3'(GREEN_STEPS);
      default: roll_steps = 3'(BLUE_STEPS);
    endcase
  end

  assign pos_inc = pos_q[cur_q] + 6'd1;

`ifdef DICE_BONUS_ROLL_EN
  assign keep_player = (roll_q == COLOR_BLUE);
`else
  assign keep_player = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      pos_q       <= '{default: '0};
      roll_q      <= '0;
      steps_q     <= '0;
      tick_q      <= '0;
      pulse_q     <= 1'b0;
      win_valid_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pos_q       <= pos_d;
      roll_q      <= roll_d;
      steps_q     <= steps_d;
      tick_q      <= tick_d;
      pulse_q     <= pulse_d;
      win_valid_q <= win_valid_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pos_d       = pos_q;
    roll_d      = roll_q;
    steps_d     = steps_q;
    tick_d      = tick_q;
    pulse_d     = 1'b0;
    win_valid_d = win_valid_q;
    winner_d    = winner_q;

    if (start) begin
      state_d     = WAIT_ROLL;
      cur_d       = '0;
      pos_d       = '{default: '0};
      roll_d      = '0;
      steps_d     = '0;
      tick_d      = '0;
      win_valid_d = 1'b0;
      winner_d    = '0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_ROLL: begin
          if (result_ready && stable_color != 2'b00) begin
            roll_d  = stable_color;
            steps_d = roll_steps;
            tick_d  = '0;
            state_d = MOVE;
          end
        end
        MOVE: begin
          // Reaching the finish ends the move at once, which also discards any overshoot.
          if (tick_q == TICK_LAST) begin
            tick_d        = '0;
            pos_d[cur_q]  = pos_inc;
            pulse_d       = 1'b1;
            steps_d       = steps_q - 3'd1;
            if (pos_inc == TRACK_END) begin
              win_valid_d = 1'b1;
              winner_d    = cur_q;
              state_d     = GAME_OVER;
            end else if (steps_q == 3'd1) begin
              state_d     = WAIT_CLEAR;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        WAIT_CLEAR: begin
          if (turn_end || current_state_white) begin
            state_d = WAIT_ROLL;
            if (!keep_player)
              cur_d = (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;
          end
        end
        GAME_OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign cur_player   = cur_q;
  assign last_roll    = roll_q;
  assign step_pulse   = pulse_q;
  assign winner_valid = win_valid_q;
  assign winner       = winner_q;

  for (genvar i = 0; i < 4; i++) begin : g_pos
    assign player_pos[6*i +: 6] = (i < NUM_PLAYERS) ? pos_q[i] : 6'd0;
  end

endmodule

// File: tb/tb_dice_race_turn_fsm.sv
// Self-checking bench for dice_race_turn_fsm: randomized turns against a per-player position model.
module tb_dice_race_turn_fsm;
  localparam int NP = 3, TL = 10, ST = 4, RS = 1, GS = 2, BS = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_WROLL = 3'd1, S_MOVE = 3'd2, S_WCLR = 3'd3, S_OVER = 3'd4;

  logic clk = 1'b0, rst_n, start, result_ready, turn_end, current_state_white;
  logic [1:0] stable_color;
  logic [2:0] state;
  logic [1:0] cur_player, last_roll, winner;
  logic [23:0] player_pos;
  logic step_pulse, winner_valid;

  int checks = 0, errors = 0;
  int mpos[NP];
  int mcur, mwinner, mroll;
  bit mwin;

  dice_race_turn_fsm #(.NUM_PLAYERS(NP), .TRACK_LEN(TL), .RED_STEPS(RS), .GREEN_STEPS(GS),
                       .BLUE_STEPS(BS), .STEP_TICKS(ST)) dut (
    .clk(clk), .reset(rst_n), .start(start), .stable_color(stable_color),
    .result_ready(result_ready), .turn_end(turn_end), .current_state_white(current_state_white),
    .state(state), .cur_player(cur_player), .player_pos(player_pos), .last_roll(last_roll),
    .step_pulse(step_pulse), .winner_valid(winner_valid), .winner(winner));

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_pos();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[6*i +: 6] = 6'(mpos[i]);
    return r;
  endfunction

  function automatic int steps_of(input logic [1:0] c);
    case (c)
      2'b01:   return RS;
      2'b10:   return GS;
      default: return BS;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) mpos[i] = 0;
    mcur = 0; mwin = 0; mwinner = 0; mroll = 0;
  endtask

  task automatic model_next_player();
`ifdef DICE_BONUS_ROLL_EN
    if (mroll == 3) return;
`endif
    mcur = (mcur + 1) % NP;
  endtask

  task automatic idle_inputs();
    start = 0; result_ready = 0; turn_end = 0; current_state_white = 0; stable_color = 2'b00;
  endtask

  // Accept a roll, follow the animated steps and compare the final board against the model.
  task automatic do_roll(input logic [1:0] c, input bit hold_white, input bit with_turn_end);
    int k, target, exp_pulses, pulses;
    bit done;
    k = steps_of(c);
    target = (mpos[mcur] + k > TL) ? TL : mpos[mcur] + k;
    exp_pulses = target - mpos[mcur];
    current_state_white = hold_white;
    stable_color = c; result_ready = 1; turn_end = with_turn_end;
    tick();
    result_ready = 0; turn_end = 0; stable_color = 2'b00;
    mroll = c;
    checks++;
    if (state !== S_MOVE || last_roll !== c) begin
      errors++;
      $display("[TB] FAIL roll_accept: state=%0d last_roll=%0d, expected state=%0d last_roll=%0d", state, last_roll, S_MOVE, c);
    end
    pulses = 0; done = 0;
    for (int t = 1; t <= (k + 1) * ST + 2 && !done; t++) begin
      tick();
      if (step_pulse === 1'b1) begin
        pulses++;
        checks++;
        if (t != pulses * ST) begin
          errors++;
          $display("[TB] FAIL step_timing: pulse %0d at cycle %0d, expected cycle %0d", pulses, t, pulses * ST);
        end
      end
      if (state !== S_MOVE) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL move_timeout: state=%0d still not left MOVE, expected exit", state);
    end
    mpos[mcur] = target;
    if (target == TL) begin mwin = 1; mwinner = mcur; end
    checks++;
    if (pulses != exp_pulses || player_pos !== exp_pos()) begin
      errors++;
      $display("[TB] FAIL move_result: pulses=%0d pos=%h, expected pulses=%0d pos=%h", pulses, player_pos, exp_pulses, exp_pos());
    end
    checks++;
    if (mwin) begin
      if (state !== S_OVER || winner_valid !== 1'b1 || winner !== 2'(mwinner)) begin
        errors++;
        $display("[TB] FAIL win_detect: state=%0d wv=%0d winner=%0d, expected state=%0d wv=1 winner=%0d", state, winner_valid, winner, S_OVER, mwinner);
      end
    end else if (state !== S_WCLR || winner_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_exit: state=%0d wv=%0d, expected state=%0d wv=0", state, winner_valid, S_WCLR);
    end
    if (hold_white && !mwin) begin
      tick();
      model_next_player();
      checks++;
      if (state !== S_WROLL || cur_player !== 2'(mcur)) begin
        errors++;
        $display("[TB] FAIL level_exit: state=%0d cur=%0d, expected state=%0d cur=%0d", state, cur_player, S_WROLL, mcur);
      end
    end
    current_state_white = 0;
  endtask

  task automatic end_turn(input bit use_level, input bit with_rr);
    if (with_rr) begin
      result_ready = 1; stable_color = 2'b11;
      tick();
      checks++;
      if (state !== S_WCLR || player_pos !== exp_pos()) begin
        errors++;
        $display("[TB] FAIL clear_ignores_roll: state=%0d pos=%h, expected state=%0d pos=%h", state, player_pos, S_WCLR, exp_pos());
      end
    end
    if (use_level) current_state_white = 1; else turn_end = 1;
    tick();
    idle_inputs();
    model_next_player();
    checks++;
    if (state !== S_WROLL || cur_player !== 2'(mcur) || player_pos !== exp_pos()) begin
      errors++;
      $display("[TB] FAIL turn_end: state=%0d cur=%0d pos=%h, expected state=%0d cur=%0d pos=%h", state, cur_player, player_pos, S_WROLL, mcur, exp_pos());
    end
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    #3;
    checks++;
    if ({state, cur_player, player_pos, last_roll, step_pulse, winner_valid, winner} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: state=%0d pos=%h wv=%0d, expected all zero", state, player_pos, winner_valid);
    end
    @(negedge clk); rst_n = 1;
    result_ready = 1; stable_color = 2'b11; turn_end = 1;
    tick(); tick();
    idle_inputs();
    checks++;
    if (state !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL idle_ignores: state=%0d, expected %0d", state, S_IDLE);
    end
  endtask

  task automatic test_start();
    start = 1; tick(); start = 0;
    model_clear();
    checks++;
    if (state !== S_WROLL || player_pos !== 24'd0 || cur_player !== 2'd0) begin
      errors++;
      $display("[TB] FAIL start: state=%0d pos=%h cur=%0d, expected state=%0d pos=0 cur=0", state, player_pos, cur_player, S_WROLL);
    end
  endtask

  task automatic test_basic_turn();
    do_roll(2'b10, 0, 0);
    end_turn(0, 0);
  endtask

  task automatic test_filtering();
    result_ready = 1; stable_color = 2'b00; tick();
    idle_inputs(); turn_end = 1; tick(); idle_inputs();
    checks++;
    if (state !== S_WROLL || cur_player !== 2'(mcur) || last_roll !== 2'(mroll)) begin
      errors++;
      $display("[TB] FAIL wait_roll_filter: state=%0d cur=%0d roll=%0d, expected state=%0d cur=%0d roll=%0d", state, cur_player, last_roll, S_WROLL, mcur, mroll);
    end
    do_roll(2'b01, 0, 0);
    end_turn(1, 1);
  endtask

  task automatic test_level_exit();
    do_roll(2'b01, 1, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      do_roll(2'b01, 0, 0);
      end_turn(0, 0);
    end
    do_roll(2'b11, 0, 1);
    end_turn(0, 0);
  endtask

  task automatic test_start_priority();
    start = 1; result_ready = 1; stable_color = 2'b10; turn_end = 1;
    tick(); idle_inputs();
    model_clear();
    checks++;
    if (state !== S_WROLL || player_pos !== 24'd0 || last_roll !== 2'd0 || cur_player !== 2'd0) begin
      errors++;
      $display("[TB] FAIL start_priority: state=%0d pos=%h roll=%0d, expected state=%0d pos=0 roll=0", state, player_pos, last_roll, S_WROLL);
    end
  endtask

  task automatic test_random_game();
    for (int turn = 0; turn < 60 && !mwin; turn++) begin
      logic [1:0] c;
      bit hw;
      c = 2'($urandom_range(1, 3));
      hw = ($urandom_range(0, 3) == 0);
      do_roll(c, hw, $urandom_range(0, 1) == 1);
      if (!mwin && !hw) end_turn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    checks++;
    if (!mwin) begin
      errors++;
      $display("[TB] FAIL game_length: no winner after 60 turns, expected a winner");
    end
  endtask

  task automatic test_game_over_hold();
    for (int i = 0; i < 6; i++) begin
      result_ready = 1; stable_color = 2'($urandom_range(0, 3));
      turn_end = 1'($urandom_range(0, 1)); current_state_white = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (state !== S_OVER || step_pulse !== 1'b0 || player_pos !== exp_pos() || winner_valid !== 1'b1 || winner !== 2'(mwinner)) begin
        errors++;
        $display("[TB] FAIL game_over_hold: state=%0d pulse=%0d pos=%h winner=%0d, expected state=%0d pulse=0 pos=%h winner=%0d", state, step_pulse, player_pos, winner, S_OVER, exp_pos(), mwinner);
      end
    end
    idle_inputs();
  endtask

  task automatic test_restart();
    start = 1; result_ready = 1; stable_color = 2'b01;
    tick(); idle_inputs();
    model_clear();
    checks++;
    if (state !== S_WROLL || player_pos !== 24'd0 || winner_valid !== 1'b0 || winner !== 2'd0 || cur_player !== 2'd0) begin
      errors++;
      $display("[TB] FAIL restart: state=%0d pos=%h wv=%0d, expected state=%0d pos=0 wv=0", state, player_pos, winner_valid, S_WROLL);
    end
  endtask

  task automatic test_reset_mid_move();
    result_ready = 1; stable_color = 2'b11; tick(); idle_inputs();
    for (int i = 0; i < ST + 2; i++) tick();
    #2 rst_n = 0;
    #1;
    model_clear();
    checks++;
    if ({state, cur_player, player_pos, last_roll, step_pulse, winner_valid, winner} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_move: state=%0d pos=%h roll=%0d, expected all zero", state, player_pos, last_roll);
    end
    @(negedge clk); rst_n = 1;
    result_ready = 1; stable_color = 2'b10;
    tick(); idle_inputs(); tick();
    checks++;
    if (state !== S_IDLE || player_pos !== 24'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: state=%0d pos=%h, expected state=%0d pos=0", state, player_pos, S_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_basic_turn();
    test_filtering();
    test_level_exit();
    test_wrap();
    test_start_priority();
    test_random_game();
    test_game_over_hold();
    test_restart();
    test_reset_mid_move();
    test_start();
    test_basic_turn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
